// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// master drives fetch/decode controls, slave is the queue.
interface if_id_queue_if #(
    parameter int ISIZE  = 16,
    parameter int IWIDTH = 32,
    parameter int DEPTH  = 2
);
    logic                     in_valid;
    logic [ISIZE-1:0]         in_pc;
    logic [IWIDTH-1:0]        in_instr;
    logic                     in_ready;
    logic                     pc_hold;
    logic                     out_valid;
    logic [ISIZE-1:0]         out_pc;
    logic [IWIDTH-1:0]        out_instr;
    logic                     out_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, pc_hold, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, pc_hold, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Instruction fetch queue between PC register and decode.
// Small FIFO of {pc, instr}; holds the PC when full, drops all on flush.
module if_id_queue #(
    parameter int                ISIZE  = 16,
    parameter int                IWIDTH = 32,
    parameter int                DEPTH  = 2,
    parameter logic [IWIDTH-1:0] NOP    = '0
) (
    input logic           clk,
    input logic           rst,
    if_id_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ISIZE-1:0]  pc_mem    [DEPTH];
    logic [IWIDTH-1:0] instr_mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              full;
    logic              push;
    logic              pop;

    // in_ready depends only on registered count (and rst), never on pop
    assign full         = (cnt == CW'(DEPTH));
    assign q.in_ready   = ~full & ~rst;
    assign q.pc_hold    = ~q.in_ready;
    assign q.out_valid  = (cnt != '0);
    assign q.out_pc     = q.out_valid ? pc_mem[rptr] : '0;
    assign q.out_instr  = q.out_valid ? instr_mem[rptr] : NOP;
    assign q.count      = cnt;

    assign push = q.in_valid & q.in_ready & ~q.flush;
    assign pop  = q.out_valid & q.out_ready & ~q.flush;

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]    <= q.in_pc;
            instr_mem[wptr] <= q.in_instr;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized plus directed bench for if_id_queue against a queue model.
module tb_if_id_queue;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    logic last_push;
    logic [15:0] fpc;

    if_id_queue_if #(.ISIZE(16), .IWIDTH(32), .DEPTH(DEPTH)) bus ();

    if_id_queue #(
        .ISIZE(16), .IWIDTH(32), .DEPTH(DEPTH), .NOP(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check outputs mid-cycle, clock, update model
    task automatic cyc(input logic r, input logic iv,
                       input logic [15:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        logic ir_m, push, pop;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        ir_m = (mq.size() < DEPTH) && !r;
        check("in_ready", 64'(bus.in_ready), 64'(ir_m));
        check("pc_hold", 64'(bus.pc_hold), 64'(!ir_m));
        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        check("out_pc", 64'(bus.out_pc),
              mq.size() != 0 ? 64'(mq[0].pc) : 64'd0);
        check("out_instr", 64'(bus.out_instr),
              mq.size() != 0 ? 64'(mq[0].instr) : 64'd0);
        check("count", 64'(bus.count), 64'(mq.size()));
        push = iv && ir_m && !fl;
        pop  = (mq.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (r || fl) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{pc: pc, instr: ins});
        end
        last_push = push && !r;
        #1;
    endtask

    // Fetch side: re-present the same pc until the queue accepts it
    task automatic fetch_until(input logic [15:0] pc, input logic [31:0] ins,
                               input logic ordy_alt);
        logic ordy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ordy = ordy_alt ? ~ordy : 1'b1;
            cyc(0, 1, pc, ins, ordy, 0);
            if (last_push) return;
        end
        check("fetch_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0;
        bus.out_ready = 0; bus.flush = 0;
        @(posedge clk); #1;

        // reset then stream
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 16'(i), 32'hA0 + 32'(i), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // decode stall fill, then drain with re-present of pc 7
        cyc(0, 1, 5, 32'hB5, 0, 0);
        cyc(0, 1, 6, 32'hB6, 0, 0);
        cyc(0, 1, 7, 32'hB7, 0, 0);
        fetch_until(7, 32'hB7, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // flush with simultaneous push/pop
        cyc(0, 1, 8, 32'hC8, 0, 0);
        cyc(0, 1, 8, 32'hC9, 0, 0);
        cyc(0, 1, 9, 32'hC9, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);

        // wrap-around with alternating out_ready
        for (int i = 0; i < 7; i++)
            fetch_until(16'h10 + 16'(i), 32'hD0 + 32'(i), 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 1, 0);

        // full plus pop in same cycle
        cyc(0, 1, 1, 32'hE1, 0, 0);
        cyc(0, 1, 2, 32'hE2, 0, 0);
        cyc(0, 1, 3, 32'hE3, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // reset mid-stream
        cyc(0, 1, 4, 32'hE4, 0, 0);
        cyc(1, 1, 5, 32'hE5, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // randomized traffic
        fpc = 16'h100;
        for (int i = 0; i < 400; i++) begin
            logic r, fl;
            r  = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 19) == 0);
            cyc(r, ($urandom_range(0, 3) != 0), fpc,
                {16'hBEEF, fpc}, 1'($urandom), fl);
            if (r || fl) fpc = 16'($urandom);
            else if (last_push) fpc = fpc + 16'd1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
